// File: rtl/layer_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_pkg
// Purpose  : Shared types and constants for the layer_tracker pipeline slots.
// Revision : 1.0 - initial release
// ============================================================================
package layer_pkg;

    typedef logic [2:0][4:0] layer_t;

    localparam int LAYER_RS  = 0;
    localparam int LAYER_RT  = 1;
    localparam int LAYER_DST = 2;

    // MIPS load-word primary opcode.
    localparam logic [5:0] OP_CODE_LW = 6'b100011;

    typedef struct packed {
        layer_t     layer;
        logic [5:0] op;
        logic       valid;
    } stage_t;

    localparam stage_t BUBBLE = '0;

endpackage : layer_pkg
`default_nettype wire

// File: rtl/layer_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_tracker_if
// Purpose  : Decoder-side inputs and per-stage register tuples of the tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_tracker_if;
    import layer_pkg::*;

    logic       id_valid;
    logic [5:0] id_op_code;
    layer_t     id_layer;
    logic       mem_stall;
    logic       flush;

    layer_t     layer_EX;
    layer_t     layer_MA;
    layer_t     layer_WB;
    logic [5:0] ex_op_code;
    logic [5:0] ma_op_code;
    logic       ex_valid;
    logic       ma_valid;
    logic       wb_valid;
    logic       stall_id;

    modport master (
        output id_valid, id_op_code, id_layer, mem_stall, flush,
        input  layer_EX, layer_MA, layer_WB, ex_op_code, ma_op_code,
        input  ex_valid, ma_valid, wb_valid, stall_id
    );

    modport slave (
        input  id_valid, id_op_code, id_layer, mem_stall, flush,
        output layer_EX, layer_MA, layer_WB, ex_op_code, ma_op_code,
        output ex_valid, ma_valid, wb_valid, stall_id
    );

endinterface : layer_tracker_if
`default_nettype wire

// File: rtl/layer_tracker_stage.sv
`default_nettype none
// ============================================================================
// Module   : layer_stage
// Purpose  : One pipeline slot; holds, loads, or collapses to a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module layer_stage
    import layer_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   i_hold,
    input  wire logic   i_bubble,
    input  wire stage_t i_stage,
    output stage_t      o_stage
);

    stage_t stage_d;
    stage_t stage_q;

    // Hold outranks bubble so a frozen pipeline never loses an instruction.
    always_comb begin
        stage_d = stage_q;
        if (!i_hold) begin
            stage_d = i_bubble ? BUBBLE : i_stage;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_stage = stage_q;

endmodule : layer_stage
`default_nettype wire

// File: rtl/layer_tracker.sv
`default_nettype none
// ============================================================================
// Module   : layer_tracker
// Purpose  : Tracks rs/rt/dest tuples through EX/MA/WB for forwarding control
//            and raises stall_id on memory stall or load-use hazard.
//            Load-use detection is built only with LOAD_USE_STALL_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module layer_tracker
    import layer_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    layer_tracker_if.slave trk
);

    stage_t w_id_stage;
    stage_t w_ex_stage;
    stage_t w_ma_stage;
    stage_t w_wb_stage;
    logic   w_load_use;
    logic   w_ex_bubble;

    always_comb begin
        w_id_stage = BUBBLE;
        if (trk.id_valid) begin
            w_id_stage.layer = trk.id_layer;
            w_id_stage.op    = trk.id_op_code;
            w_id_stage.valid = 1'b1;
        end
    end

`ifdef LOAD_USE_STALL_EN
    // A zero destination never forwards, so a load into $0 cannot create a hazard.
    always_comb begin
        w_load_use = w_ex_stage.valid
                  && (w_ex_stage.op == OP_CODE_LW)
                  && (w_ex_stage.layer[LAYER_DST] != 5'd0)
                  && trk.id_valid
                  && ((w_ex_stage.layer[LAYER_DST] == trk.id_layer[LAYER_RS])
                   || (w_ex_stage.layer[LAYER_DST] == trk.id_layer[LAYER_RT]));
    end
`else
    assign w_load_use = 1'b0;
`endif

    assign w_ex_bubble  = trk.flush || w_load_use;
    // Flush discards the dependent instruction, so it cancels the hazard stall.
    assign trk.stall_id = !rst && (trk.mem_stall || (!trk.flush && w_load_use));

    layer_stage u_stage_ex (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (trk.mem_stall),
        .i_bubble (w_ex_bubble),
        .i_stage  (w_id_stage),
        .o_stage  (w_ex_stage)
    );

    layer_stage u_stage_ma (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (trk.mem_stall),
        .i_bubble (1'b0),
        .i_stage  (w_ex_stage),
        .o_stage  (w_ma_stage)
    );

    layer_stage u_stage_wb (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (trk.mem_stall),
        .i_bubble (1'b0),
        .i_stage  (w_ma_stage),
        .o_stage  (w_wb_stage)
    );

    assign trk.layer_EX   = w_ex_stage.layer;
    assign trk.layer_MA   = w_ma_stage.layer;
    assign trk.layer_WB   = w_wb_stage.layer;
    assign trk.ex_op_code = w_ex_stage.op;
    assign trk.ma_op_code = w_ma_stage.op;
    assign trk.ex_valid   = w_ex_stage.valid;
    assign trk.ma_valid   = w_ma_stage.valid;
    assign trk.wb_valid   = w_wb_stage.valid;

endmodule : layer_tracker
`default_nettype wire

// File: tb/tb_layer_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_tracker
// Purpose  : Directed self-checking bench for layer_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_tracker;
    import layer_pkg::*;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;

`ifdef LOAD_USE_STALL_EN
    localparam logic LU_EN = 1'b1;
`else
    localparam logic LU_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    layer_tracker_if bus ();

    layer_tracker dut (
        .clk (clk),
        .rst (rst),
        .trk (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [5:0] op,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
        bus.id_valid   = v;
        bus.id_op_code = op;
        bus.id_layer   = {dst, rt, rs};
        #1;
    endtask

    task automatic idle_drain(input int n);
        present(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mem_stall = 1'b1; bus.flush = 1'b0;
        present(1'b1, OP_LW, 5'd1, 5'd5, 5'd5);
        step(); step();
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_id); end
        checks++; if ({bus.layer_EX, bus.layer_MA, bus.layer_WB} !== 45'd0) begin failures++; $display("FAIL reset_layers got=%h exp=0", {bus.layer_EX, bus.layer_MA, bus.layer_WB}); end
        checks++; if ({bus.ex_valid, bus.ma_valid, bus.wb_valid, bus.ex_op_code, bus.ma_op_code} !== 15'd0) begin failures++; $display("FAIL reset_ctl got=%h exp=0", {bus.ex_valid, bus.ma_valid, bus.wb_valid, bus.ex_op_code, bus.ma_op_code}); end
        bus.mem_stall = 1'b0;
        present(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_latency();
        present(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL lat_stall got=%b exp=0", bus.stall_id); end
        step();
        present(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        checks++; if (bus.layer_EX !== {5'd3, 5'd2, 5'd1} || bus.ex_valid !== 1'b1 || bus.ex_op_code !== OP_ADD) begin failures++; $display("FAIL lat_ex got=%h/%b/%h exp=0c41/1/00", bus.layer_EX, bus.ex_valid, bus.ex_op_code); end
        step();
        checks++; if (bus.layer_MA !== {5'd3, 5'd2, 5'd1} || bus.ma_valid !== 1'b1 || bus.ex_valid !== 1'b0 || bus.layer_EX !== 15'd0) begin failures++; $display("FAIL lat_ma got=%h/%b ex_valid=%b exp=0c41/1 ex_valid=0", bus.layer_MA, bus.ma_valid, bus.ex_valid); end
        step();
        checks++; if (bus.layer_WB !== {5'd3, 5'd2, 5'd1} || bus.wb_valid !== 1'b1 || bus.ma_valid !== 1'b0) begin failures++; $display("FAIL lat_wb got=%h/%b ma_valid=%b exp=0c41/1 ma_valid=0", bus.layer_WB, bus.wb_valid, bus.ma_valid); end
        step();
        checks++; if (bus.wb_valid !== 1'b0 || bus.layer_WB !== 15'd0) begin failures++; $display("FAIL lat_drop got=%b/%h exp=0/0", bus.wb_valid, bus.layer_WB); end
    endtask

    task automatic test_load_use();
        present(1'b1, OP_LW, 5'd1, 5'd5, 5'd5);
        step();
        present(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6);
        checks++; if (bus.stall_id !== LU_EN) begin failures++; $display("FAIL lu_stall got=%b exp=%b", bus.stall_id, LU_EN); end
        step();
        if (LU_EN) begin
            checks++; if (bus.ex_valid !== 1'b0 || bus.layer_EX !== 15'd0 || bus.ma_op_code !== OP_LW) begin failures++; $display("FAIL lu_bubble got=ex_valid %b ma_op %h exp=0/23", bus.ex_valid, bus.ma_op_code); end
            checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", bus.stall_id); end
            step();
        end
        checks++; if (bus.layer_EX !== {5'd6, 5'd7, 5'd5} || bus.ex_op_code !== OP_ADD || bus.ex_valid !== 1'b1) begin failures++; $display("FAIL lu_add_ex got=%h/%h exp=18e5/00", bus.layer_EX, bus.ex_op_code); end
        idle_drain(3);
    endtask

    task automatic test_no_dep();
        present(1'b1, OP_LW, 5'd1, 5'd5, 5'd5);
        step();
        present(1'b1, OP_ADDI, 5'd9, 5'd8, 5'd8);
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL nodep_stall got=%b exp=0", bus.stall_id); end
        step();
        checks++; if (bus.layer_EX !== {5'd8, 5'd8, 5'd9} || bus.ma_op_code !== OP_LW) begin failures++; $display("FAIL nodep_ex got=%h ma_op=%h exp=2109/23", bus.layer_EX, bus.ma_op_code); end
        idle_drain(3);
    endtask

    task automatic test_zero_reg();
        present(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
        step();
        present(1'b1, OP_ADD, 5'd0, 5'd0, 5'd4);
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", bus.stall_id); end
        step();
        checks++; if (bus.layer_EX !== {5'd4, 5'd0, 5'd0} || bus.ex_valid !== 1'b1) begin failures++; $display("FAIL zero_ex got=%h/%b exp=1000/1", bus.layer_EX, bus.ex_valid); end
        idle_drain(3);
    endtask

    task automatic test_flush();
        present(1'b1, OP_LW, 5'd1, 5'd5, 5'd5);
        step();
        present(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_id); end
        step();
        bus.flush = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.layer_EX !== 15'd0 || bus.ma_op_code !== OP_LW || bus.ma_valid !== 1'b1 || bus.layer_MA !== {5'd5, 5'd5, 5'd1}) begin failures++; $display("FAIL flush_slots got=ex_valid %b ma %h/%h/%b exp=0 14a1/23/1", bus.ex_valid, bus.layer_MA, bus.ma_op_code, bus.ma_valid); end
        idle_drain(3);
    endtask

    task automatic test_mem_stall();
        present(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
        step();
        present(1'b1, OP_ADDI, 5'd4, 5'd10, 5'd10);
        step();
        present(1'b1, OP_ADD, 5'd11, 5'd12, 5'd13);
        step();
        present(1'b1, OP_ADD, 5'd14, 5'd15, 5'd16);
        bus.mem_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL ms_stall[%0d] got=%b exp=1", i, bus.stall_id); end
            checks++; if (bus.layer_EX !== {5'd13, 5'd12, 5'd11} || bus.layer_MA !== {5'd10, 5'd10, 5'd4} || bus.layer_WB !== {5'd3, 5'd2, 5'd1}
                          || bus.ex_op_code !== OP_ADD || bus.ma_op_code !== OP_ADDI || {bus.ex_valid, bus.ma_valid, bus.wb_valid} !== 3'b111) begin
                failures++; $display("FAIL ms_hold[%0d] got=%h/%h/%h exp=358b/2944/0c41", i, bus.layer_EX, bus.layer_MA, bus.layer_WB);
            end
            step();
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL ms_rst_stall got=%b exp=0", bus.stall_id); end
        step();
        checks++; if ({bus.layer_EX, bus.layer_MA, bus.layer_WB, bus.ex_valid, bus.ma_valid, bus.wb_valid, bus.ex_op_code, bus.ma_op_code} !== 60'd0) begin failures++; $display("FAIL ms_rst_clear got=%h/%h/%h exp=0", bus.layer_EX, bus.layer_MA, bus.layer_WB); end
        rst = 1'b0; bus.mem_stall = 1'b0;
        present(1'b1, OP_ADDI, 5'd2, 5'd9, 5'd9);
        step();
        checks++; if (bus.layer_EX !== {5'd9, 5'd9, 5'd2} || bus.ex_valid !== 1'b1) begin failures++; $display("FAIL post_rst_normal got=%h/%b exp=2522/1", bus.layer_EX, bus.ex_valid); end
        idle_drain(3);
    endtask

    task automatic test_back_to_back();
        present(1'b1, OP_LW, 5'd1, 5'd5, 5'd5);
        step();
        present(1'b1, OP_LW, 5'd5, 5'd6, 5'd6);
        checks++; if (bus.stall_id !== LU_EN) begin failures++; $display("FAIL b2b_stall1 got=%b exp=%b", bus.stall_id, LU_EN); end
        if (LU_EN) step();
        checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL b2b_release1 got=%b exp=0", bus.stall_id); end
        step();
        present(1'b1, OP_ADD, 5'd6, 5'd2, 5'd7);
        checks++; if (bus.stall_id !== LU_EN || bus.layer_EX !== {5'd6, 5'd6, 5'd5}) begin failures++; $display("FAIL b2b_stall2 got=%b ex=%h exp=%b/18c5", bus.stall_id, bus.layer_EX, LU_EN); end
        if (LU_EN) begin
            step();
            checks++; if (bus.ex_valid !== 1'b0 || bus.layer_MA !== {5'd6, 5'd6, 5'd5}) begin failures++; $display("FAIL b2b_bubble2 got=%b ma=%h exp=0/18c5", bus.ex_valid, bus.layer_MA); end
        end
        step();
        checks++; if (bus.layer_EX !== {5'd7, 5'd2, 5'd6} || bus.ex_op_code !== OP_ADD) begin failures++; $display("FAIL b2b_add_ex got=%h/%h exp=1c46/00", bus.layer_EX, bus.ex_op_code); end
        idle_drain(3);
    endtask

    initial begin
        bus.id_valid = 1'b0; bus.id_op_code = '0; bus.id_layer = '0;
        bus.mem_stall = 1'b0; bus.flush = 1'b0; rst = 1'b1;
        test_reset();
        test_latency();
        test_load_use();
        test_no_dep();
        test_zero_reg();
        test_flush();
        test_mem_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_layer_tracker
`default_nettype wire
